// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue sequencer.
//   - ISA opcode constants and ALU function-select constants
//   - FSM state encoding (enum plus legacy-compatible localparams)
//   - instruction field bit positions
//   - decoder result record
package alu_issue_pkg;

    localparam int DATA_W   = 32;
    localparam int IDX_W    = 4;
    localparam int OPC_W    = 5;
    localparam int ALU_OP_W = 5;
    localparam int IMM_W    = 19;

    // Instruction field positions.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int IMM_MSB = 18;
    localparam int IMM_LSB = 0;

    // ISA opcodes.
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10010;

    // ALU function selects.
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_NEG  = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SHR  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_ROR  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_ROL  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SHRA = 5'd9;

    // FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_READ = S_READ;
    localparam logic [1:0] ST_EXEC = S_EXEC;
    localparam logic [1:0] ST_WB   = S_WB;

    // Decoder result.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                unary;   // A-only op: B operand forced to zero
        logic                imm;     // B operand comes from sign-extended imm19
        logic                legal;
    } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of every non-clock signal around the issue sequencer.
//   master : the sequencer side (drives instr_ready, register-file indices,
//            ALU operands/op, writeback channel and the illegal pulse)
//   slave  : the environment side (instruction source, register file, ALU,
//            writeback sink)
// alu_a / alu_b are declared [0:31]: bit 0 is the MSB, matching the ALU ports.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [DATA_W-1:0]   instr;
    logic [IDX_W-1:0]    rf_rb_idx;
    logic [IDX_W-1:0]    rf_rc_idx;
    logic [DATA_W-1:0]   rf_rb_data;
    logic [DATA_W-1:0]   rf_rc_data;
    logic [0:DATA_W-1]   alu_a;
    logic [0:DATA_W-1]   alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_c;
    logic                wb_valid;
    logic                wb_ready;
    logic [IDX_W-1:0]    wb_idx;
    logic [DATA_W-1:0]   wb_data;
    logic                illegal;

    modport master (
        input  instr_valid, instr, rf_rb_data, rf_rc_data, alu_c, wb_ready,
        output instr_ready, rf_rb_idx, rf_rc_idx, alu_a, alu_b, alu_op,
               wb_valid, wb_idx, wb_data, illegal
    );

    modport slave (
        output instr_valid, instr, rf_rb_data, rf_rc_data, alu_c, wb_ready,
        input  instr_ready, rf_rb_idx, rf_rc_idx, alu_a, alu_b, alu_op,
               wb_valid, wb_idx, wb_data, illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational opcode -> {alu_op, unary, imm, legal}.
//   opcode_i : 5-bit ISA opcode
//   dec_o    : decoded ALU select and operand-routing flags
// Build option: ALU_ISSUE_IMM_EN enables ADDI/ANDI/ORI; when undefined those
// opcodes fall through to illegal.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output dec_t             dec_o
);

    // NOTE: every output gets a default before the case so no path leaves a
    // bit unassigned -- that is what keeps this block free of inferred latches.
    always_comb begin
        dec_o       = '0;
        dec_o.legal = 1'b1;
        case (opcode_i)
            OPC_ADD:  dec_o.alu_op = ALU_ADD;
            OPC_SUB:  dec_o.alu_op = ALU_SUB;
            OPC_AND:  dec_o.alu_op = ALU_AND;
            OPC_OR:   dec_o.alu_op = ALU_OR;
            OPC_SHR:  begin dec_o.alu_op = ALU_SHR;  dec_o.unary = 1'b1; end
            OPC_SHRA: begin dec_o.alu_op = ALU_SHRA; dec_o.unary = 1'b1; end
            OPC_SHL:  begin dec_o.alu_op = ALU_SHL;  dec_o.unary = 1'b1; end
            OPC_ROR:  begin dec_o.alu_op = ALU_ROR;  dec_o.unary = 1'b1; end
            OPC_ROL:  begin dec_o.alu_op = ALU_ROL;  dec_o.unary = 1'b1; end
            OPC_NEG:  begin dec_o.alu_op = ALU_NEG;  dec_o.unary = 1'b1; end
`ifdef ALU_ISSUE_IMM_EN
            OPC_ADDI: begin dec_o.alu_op = ALU_ADD;  dec_o.imm = 1'b1; end
            OPC_ANDI: begin dec_o.alu_op = ALU_AND;  dec_o.imm = 1'b1; end
            OPC_ORI:  begin dec_o.alu_op = ALU_OR;   dec_o.imm = 1'b1; end
`endif
            default:  dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer in front of the datapath ALU.
//   clock   : rising-edge system clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_issue_if.master -- instruction handshake, register-file
//             read port, ALU operand/result port, writeback handshake and
//             the illegal-opcode pulse
// Flow: IDLE (accept) -> READ (register fetch, operand latch) -> EXEC (ALU
// result captured) -> WB (held until wb_ready). Illegal opcodes pulse
// `illegal` for one cycle and never leave IDLE.
// Build option: ALU_ISSUE_IMM_EN adds ADDI/ANDI/ORI with a sign-extended
// imm19 B operand; without it the immediate path is absent.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    alu_issue_if.master bus
);

    logic [1:0]          state_q,   state_d;
    logic [DATA_W-1:0]   instr_q,   instr_d;
    logic [DATA_W-1:0]   result_q,  result_d;
    logic [0:DATA_W-1]   alu_a_q,   alu_a_d;
    logic [0:DATA_W-1]   alu_b_q,   alu_b_d;
    logic [ALU_OP_W-1:0] alu_op_q,  alu_op_d;
    logic                illegal_q, illegal_d;

    // The single decoder looks at the offered word while IDLE (so an illegal
    // opcode is known at the accept edge and never leaves IDLE) and at the
    // latched word afterwards (to select operands in READ).
    logic [OPC_W-1:0] dec_opcode;
    dec_t             dec;

    assign dec_opcode = (state_q == ST_IDLE) ? bus.instr[OPC_MSB:OPC_LSB]
                                             : instr_q[OPC_MSB:OPC_LSB];

    alu_issue_decode u_decode (
        .opcode_i (dec_opcode),
        .dec_o    (dec)
    );

`ifdef ALU_ISSUE_IMM_EN
    logic [DATA_W-1:0] imm_sext;
    assign imm_sext = {{(DATA_W-IMM_W){instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};
`else
    // Low instruction bits and the imm flag have no consumer in this build.
    logic unused_imm;
    assign unused_imm = ^{instr_q[RC_LSB-1:0], dec.imm};
`endif

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        result_d  = result_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    if (dec.legal) begin
                        instr_d = bus.instr;
                        state_d = ST_READ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                alu_a_d = bus.rf_rb_data;
                if (dec.unary) begin
                    alu_b_d = '0;
`ifdef ALU_ISSUE_IMM_EN
                end else if (dec.imm) begin
                    alu_b_d = imm_sext;
`endif
                end else begin
                    alu_b_d = bus.rf_rc_data;
                end
                alu_op_d = dec.alu_op;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = bus.alu_c;
                state_d  = ST_WB;
            end
            ST_WB: begin
                if (bus.wb_ready) begin
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.rf_rb_idx   = (state_q == ST_READ) ? instr_q[RB_MSB:RB_LSB] : '0;
    assign bus.rf_rc_idx   = (state_q == ST_READ) ? instr_q[RC_MSB:RC_LSB] : '0;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.wb_valid    = (state_q == ST_WB);
    assign bus.wb_idx      = (state_q == ST_WB) ? instr_q[RA_MSB:RA_LSB] : '0;
    assign bus.wb_data     = (state_q == ST_WB) ? result_q : '0;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    alu_issue_if bus ();

    alu_issue dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Register file: combinational read.
    logic [31:0] rf [16];
    assign bus.rf_rb_data = rf[bus.rf_rb_idx];
    assign bus.rf_rc_data = rf[bus.rf_rc_idx];

    // Reference ALU, combinational from the operand ports.
    logic [31:0] ma, mb;
    always_comb begin
        ma = bus.alu_a;
        mb = bus.alu_b;
        case (bus.alu_op)
            5'd0:    bus.alu_c = ma | mb;
            5'd1:    bus.alu_c = ma & mb;
            5'd2:    bus.alu_c = ma + mb;
            5'd3:    bus.alu_c = ma - mb;
            5'd4:    bus.alu_c = 32'd0 - ma;
            5'd5:    bus.alu_c = ma >> 1;
            5'd6:    bus.alu_c = ma << 1;
            5'd7:    bus.alu_c = {ma[0], ma[31:1]};
            5'd8:    bus.alu_c = {ma[30:0], ma[31]};
            5'd9:    bus.alu_c = {ma[31], ma[31:1]};
            default: bus.alu_c = 32'd0;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [4:0] opc, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [4:0] opc, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [18:0] imm);
        return {opc, ra, rb, imm};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rb_val;
        logic [31:0] rc_val;
        logic        ill;
        logic [4:0]  op;
        logic [31:0] b;
        logic [3:0]  idx;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [31:0] ins,
                                input logic [31:0] bv, input logic [31:0] cv,
                                input logic ill, input logic [4:0] op,
                                input logic [31:0] b, input logic [3:0] idx,
                                input logic [31:0] d);
        vec_t v;
        v.name = n; v.instr = ins; v.rb_val = bv; v.rc_val = cv; v.ill = ill;
        v.op = op; v.b = b; v.idx = idx; v.data = d;
        return v;
    endfunction

    // One instruction from offer to return to IDLE, wb_ready held high.
    task automatic run_vec(input vec_t v);
        @(negedge clock);
        rf[v.instr[18:15]] = v.rc_val;
        rf[v.instr[22:19]] = v.rb_val;
        bus.instr       = v.instr;
        bus.instr_valid = 1'b1;
        bus.wb_ready    = 1'b1;
        @(posedge clock); #1;               // cycle 1
        bus.instr_valid = 1'b0;
        check({v.name, ".illegal_c1"}, bus.illegal, v.ill);
        check({v.name, ".ready_c1"}, bus.instr_ready, v.ill);
        if (v.ill) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clock); #1;
                check({v.name, ".no_wb"}, bus.wb_valid, 1'b0);
                check({v.name, ".illegal_low"}, bus.illegal, 1'b0);
            end
        end else begin
            @(posedge clock); #1;           // cycle 2: EXEC
            check({v.name, ".alu_op"}, bus.alu_op, v.op);
            check({v.name, ".alu_a"}, bus.alu_a, v.rb_val);
            check({v.name, ".alu_b"}, bus.alu_b, v.b);
            check({v.name, ".wb_valid_c2"}, bus.wb_valid, 1'b0);
            @(posedge clock); #1;           // cycle 3: WB
            check({v.name, ".wb_valid"}, bus.wb_valid, 1'b1);
            check({v.name, ".wb_idx"}, bus.wb_idx, v.idx);
            check({v.name, ".wb_data"}, bus.wb_data, v.data);
            @(posedge clock); #1;           // back in IDLE
            check({v.name, ".ready_after"}, bus.instr_ready, 1'b1);
            check({v.name, ".wb_valid_after"}, bus.wb_valid, 1'b0);
            check({v.name, ".alu_op_clr"}, bus.alu_op, 5'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".instr_ready"}, bus.instr_ready, 1'b1);
        check({tag, ".rf_rb_idx"}, bus.rf_rb_idx, 4'd0);
        check({tag, ".rf_rc_idx"}, bus.rf_rc_idx, 4'd0);
        check({tag, ".alu_a"}, bus.alu_a, 32'd0);
        check({tag, ".alu_b"}, bus.alu_b, 32'd0);
        check({tag, ".alu_op"}, bus.alu_op, 5'd0);
        check({tag, ".wb_valid"}, bus.wb_valid, 1'b0);
        check({tag, ".wb_idx"}, bus.wb_idx, 4'd0);
        check({tag, ".wb_data"}, bus.wb_data, 32'd0);
        check({tag, ".illegal"}, bus.illegal, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic imm_ill;
`ifdef ALU_ISSUE_IMM_EN
        imm_ill = 1'b0;
`else
        imm_ill = 1'b1;
`endif
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.wb_ready    = 1'b0;

        // Reset state.
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vector table.
        vecs.push_back(mk("add",  32'h18918000,             32'd5,          32'd7,          1'b0, 5'd2, 32'd7,          4'd1, 32'd12));
        vecs.push_back(mk("sub",  rr(5'b00100, 4, 2, 3),   32'd5,          32'd7,          1'b0, 5'd3, 32'd7,          4'd4, 32'hFFFFFFFE));
        vecs.push_back(mk("neg",  rr(5'b10010, 5, 2, 3),   32'd1,          32'd7,          1'b0, 5'd4, 32'd0,          4'd5, 32'hFFFFFFFF));
        vecs.push_back(mk("and",  rr(5'b01010, 7, 8, 9),   32'hF0F000FF,   32'h0FF00F0F,   1'b0, 5'd1, 32'h0FF00F0F,   4'd7, 32'h00F0000F));
        vecs.push_back(mk("or",   rr(5'b01011, 1, 8, 9),   32'hF0F000FF,   32'h0FF00F0F,   1'b0, 5'd0, 32'h0FF00F0F,   4'd1, 32'hFFF00FFF));
        vecs.push_back(mk("shr",  rr(5'b00101, 2, 8, 9),   32'h80000001,   32'hDEADBEEF,   1'b0, 5'd5, 32'd0,          4'd2, 32'h40000000));
        vecs.push_back(mk("shra", rr(5'b00110, 3, 8, 9),   32'h80000001,   32'hDEADBEEF,   1'b0, 5'd9, 32'd0,          4'd3, 32'hC0000000));
        vecs.push_back(mk("shl",  rr(5'b00111, 4, 8, 9),   32'h80000001,   32'hDEADBEEF,   1'b0, 5'd6, 32'd0,          4'd4, 32'h00000002));
        vecs.push_back(mk("ror",  rr(5'b01000, 5, 8, 9),   32'h80000001,   32'hDEADBEEF,   1'b0, 5'd7, 32'd0,          4'd5, 32'hC0000000));
        vecs.push_back(mk("rol",  rr(5'b01001, 6, 8, 9),   32'h80000001,   32'hDEADBEEF,   1'b0, 5'd8, 32'd0,          4'd6, 32'h00000003));
        vecs.push_back(mk("addi", ri(5'b01100, 6, 2, 19'h7FFFF), 32'd10,    32'd0,          imm_ill, 5'd2, 32'hFFFFFFFF, 4'd6, 32'd9));
        vecs.push_back(mk("andi", ri(5'b01101, 7, 2, 19'h0000F), 32'h1234,  32'd0,          imm_ill, 5'd1, 32'h0000000F, 4'd7, 32'h4));
        vecs.push_back(mk("ori",  ri(5'b01110, 1, 2, 19'h40000), 32'h1234,  32'd0,          imm_ill, 5'd0, 32'hFFFC0000, 4'd1, 32'hFFFC1234));
        vecs.push_back(mk("op1f", rr(5'b11111, 1, 2, 3),   32'd5,          32'd7,          1'b1, 5'd0, 32'd0,          4'd0, 32'd0));
        vecs.push_back(mk("op00", rr(5'b00000, 1, 2, 3),   32'd5,          32'd7,          1'b1, 5'd0, 32'd0,          4'd0, 32'd0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal opcode followed immediately by a legal ADD in cycle 1.
        @(negedge clock);
        rf[2] = 32'd5; rf[3] = 32'd7;
        bus.wb_ready    = 1'b1;
        bus.instr       = 32'hF8000000;
        bus.instr_valid = 1'b1;
        @(posedge clock); #1;
        check("ill_then_add.illegal_c1", bus.illegal, 1'b1);
        check("ill_then_add.ready_c1", bus.instr_ready, 1'b1);
        bus.instr = 32'h18918000;
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        check("ill_then_add.read_ready", bus.instr_ready, 1'b0);
        check("ill_then_add.rb_idx", bus.rf_rb_idx, 4'd2);
        check("ill_then_add.rc_idx", bus.rf_rc_idx, 4'd3);
        check("ill_then_add.illegal_c2", bus.illegal, 1'b0);
        @(posedge clock); #1;
        check("ill_then_add.alu_op", bus.alu_op, 5'd2);
        @(posedge clock); #1;
        check("ill_then_add.wb_valid", bus.wb_valid, 1'b1);
        check("ill_then_add.wb_data", bus.wb_data, 32'd12);
        @(posedge clock); #1;
        check("ill_then_add.idle", bus.instr_ready, 1'b1);

        // Writeback backpressure for 10 cycles, with a new instruction offered.
        @(negedge clock);
        bus.wb_ready    = 1'b0;
        bus.instr       = rr(5'b00100, 4, 2, 3);
        bus.instr_valid = 1'b1;
        @(posedge clock); #1;
        bus.instr = 32'h18918000;         // stays offered; must not be taken
        repeat (2) @(posedge clock);
        #1;
        check("bp.wb_valid_c3", bus.wb_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp.wb_valid", bus.wb_valid, 1'b1);
            check("bp.wb_idx", bus.wb_idx, 4'd4);
            check("bp.wb_data", bus.wb_data, 32'hFFFFFFFE);
            check("bp.ready", bus.instr_ready, 1'b0);
            check("bp.alu_op", bus.alu_op, 5'd3);
        end
        bus.instr_valid = 1'b0;
        bus.wb_ready    = 1'b1;
        @(posedge clock); #1;
        check("bp.release_wb_valid", bus.wb_valid, 1'b0);
        check("bp.release_ready", bus.instr_ready, 1'b1);
        check("bp.release_alu_a", bus.alu_a, 32'd0);
        check("bp.release_alu_b", bus.alu_b, 32'd0);

        // Reset asserted while in EXEC.
        @(negedge clock);
        bus.instr       = 32'h18918000;
        bus.instr_valid = 1'b1;
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        @(posedge clock); #1;
        check("rst.exec_alu_op", bus.alu_op, 5'd2);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst.mid_exec");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("rst.no_wb", bus.wb_valid, 1'b0);
            check("rst.ready", bus.instr_ready, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
